// File: rtl/gray_window_3x3.sv
// gray_window_3x3: streams raster gray pixels through two line buffers and emits 3x3 windows.
module gray_window_3x3 #(
  parameter int MAX_WIDTH = 640,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic [15:0]   width,
  input  logic [15:0]   height,
  input  logic [DW-1:0] pix_in,
  input  logic          pix_valid,
  output logic [9*DW-1:0] win,
  output logic          win_valid,
  output logic          busy,
  output logic          frame_done,
  output logic          cfg_err
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  localparam int AW = MAX_WIDTH > 1 ? $clog2(MAX_WIDTH) : 1;
  logic [1:0] state_q, state_d;
  logic [15:0] width_q, width_d, height_q, height_d, col_q, col_d, row_q, row_d;
  logic [9*DW-1:0] sr_q, sr_d, sr_n, win_q, win_d;
  logic win_valid_q, win_valid_d, cfg_err_q, cfg_err_d;
  logic [DW-1:0] lb0 [MAX_WIDTH];
  logic [DW-1:0] lb1 [MAX_WIDTH];
  logic [AW-1:0] addr;
  logic accept, emit, last, eol, bad;
  assign addr   = col_q[AW-1:0];
  assign accept = state_q == RUN && pix_valid && !start;
  assign eol    = col_q == width_q - 16'd1;
  assign last   = accept && eol && row_q == height_q - 16'd1;
  assign emit   = accept && row_q >= 16'd2 && col_q >= 16'd2;
  assign bad    = width < 16'd3 || height < 16'd3 || width > 16'(MAX_WIDTH);
  // Each window row drops its oldest pixel; the new column enters on the right.
  assign sr_n = {sr_q[8*DW-1:6*DW], lb1[addr], sr_q[5*DW-1:3*DW], lb0[addr], sr_q[2*DW-1:0], pix_in};
  always_comb begin
    state_d     = state_q == DONE ? IDLE : last ? DONE : state_q;
    width_d     = width_q;
    height_d    = height_q;
    col_d       = accept ? (eol ? 16'd0 : col_q + 16'd1) : col_q;
    row_d       = accept && eol ? row_q + 16'd1 : row_q;
    sr_d        = accept ? sr_n : sr_q;
    win_d       = emit ? sr_n : win_q;
    win_valid_d = emit;
    cfg_err_d   = cfg_err_q;
    if (start) begin
      state_d   = bad ? IDLE : RUN;
      cfg_err_d = bad;
      width_d   = width;
      height_d  = height;
      col_d     = '0;
      row_d     = '0;
      sr_d      = '0;
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      width_q     <= '0;
      height_q    <= '0;
      col_q       <= '0;
      row_q       <= '0;
      sr_q        <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      width_q     <= width_d;
      height_q    <= height_d;
      col_q       <= col_d;
      row_q       <= row_d;
      sr_q        <= sr_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      cfg_err_q   <= cfg_err_d;
    end
  end
  // Stale line-buffer data is never seen: rows 0 and 1 refill a column before row 2 reads it.
  always_ff @(posedge clk) begin
    if (accept) begin
      lb0[addr] <= pix_in;
      lb1[addr] <= lb0[addr];
    end
  end
  assign win        = win_q;
  assign win_valid  = win_valid_q;
  assign busy       = state_q == RUN;
  assign frame_done = state_q == DONE;
  assign cfg_err    = cfg_err_q;
endmodule

// File: tb/tb_gray_window_3x3.sv
// tb_gray_window_3x3: directed frame sequence with random data and gaps, checked against an image model.
module tb_gray_window_3x3;
  localparam int MW = 640;
  localparam int DW = 8;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, pix_valid = 1'b0;
  logic [15:0] width = '0, height = '0;
  logic [DW-1:0] pix_in = '0;
  logic [9*DW-1:0] win;
  logic win_valid, busy, frame_done, cfg_err;
  int total = 0, passed = 0;
  logic [DW-1:0] img [0:7][0:MW-1];
  logic [9*DW-1:0] last_win = '0, first_win = '0;
  always #5 clk = ~clk;
  gray_window_3x3 #(.MAX_WIDTH(MW), .DW(DW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .width(width), .height(height),
    .pix_in(pix_in), .pix_valid(pix_valid), .win(win), .win_valid(win_valid),
    .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err)
  );
  task automatic chk(input string tag, input logic [9*DW-1:0] got, input logic [9*DW-1:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_start(input int w, input int h);
    logic legal;
    legal = w >= 3 && h >= 3 && w <= MW;
    start = 1'b1;
    width = 16'(w);
    height = 16'(h);
    pix_valid = 1'b1;
    pix_in = DW'($urandom);
    tick;
    start = 1'b0;
    pix_valid = 1'b0;
    chk("start_busy", busy, legal);
    chk("start_cfg_err", cfg_err, !legal);
    chk("start_win_valid", win_valid, 0);
  endtask
  task automatic ignore(input int n);
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_in = DW'($urandom);
      tick;
      chk("ignored_win_valid", win_valid, 0);
      chk("ignored_busy", busy, 0);
      chk("ignored_win_held", win, last_win);
    end
    pix_valid = 1'b0;
  endtask
  // mode 0: 10*r+c, mode 1: random, mode 2: raster ramp r*w+c
  task automatic run_frame(input int w, input int h, input int npix, input int mode, input int gap);
    int r, c, nwin;
    logic [9*DW-1:0] e;
    nwin = 0;
    for (int k = 0; k < npix; k++) begin
      r = k / w;
      c = k % w;
      if ($urandom_range(99) < gap) begin
        pix_valid = 1'b0;
        pix_in = DW'($urandom);
        tick;
        chk("gap_win_valid", win_valid, 0);
        chk("gap_win_held", win, last_win);
        chk("gap_frame_done", frame_done, 0);
      end
      img[r][c] = mode == 0 ? DW'(10 * r + c) : mode == 1 ? DW'($urandom) : DW'(r * w + c);
      pix_in = img[r][c];
      pix_valid = 1'b1;
      tick;
      pix_valid = 1'b0;
      if (r >= 2 && c >= 2) begin
        e = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e = {e[8*DW-1:0], img[r-2+i][c-2+j]};
        last_win = e;
        if (nwin == 0) first_win = e;
        nwin++;
      end
      chk("win_valid", win_valid, r >= 2 && c >= 2);
      chk("win", win, last_win);
      chk("frame_done", frame_done, k == w * h - 1);
    end
    if (npix == w * h) chk("window_count", nwin, (w - 2) * (h - 2));
  endtask
  task automatic after_frame;
    tick;
    chk("post_busy", busy, 0);
    chk("post_frame_done", frame_done, 0);
    chk("post_win_valid", win_valid, 0);
    chk("post_win_held", win, last_win);
  endtask
  initial begin
    #12;
    chk("rst_win", win, 0);
    chk("rst_win_valid", win_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_cfg_err", cfg_err, 0);
    #3 rstn = 1'b1;
    ignore(5);
    do_start(5, 4);
    run_frame(5, 4, 20, 0, 0);
    chk("first_win", first_win, 72'h0001020A0B0C141516);
    after_frame;
    ignore(3);
    do_start(5, 4);
    run_frame(5, 4, 20, 0, 40);
    chk("gapped_first_win", first_win, 72'h0001020A0B0C141516);
    after_frame;
    do_start(7, 5);
    run_frame(7, 5, 35, 1, 30);
    after_frame;
    do_start(2, 4);
    ignore(6);
    do_start(MW + 1, 3);
    ignore(6);
    do_start(5, 2);
    ignore(2);
    do_start(5, 4);
    run_frame(5, 4, 12, 0, 0);
    do_start(4, 3);
    run_frame(4, 3, 12, 1, 0);
    after_frame;
    do_start(5, 4);
    run_frame(5, 4, 14, 0, 0);
    #2 rstn = 1'b0;
    #1;
    chk("async_rst_win", win, 0);
    chk("async_rst_win_valid", win_valid, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_frame_done", frame_done, 0);
    last_win = '0;
    @(posedge clk);
    #2 rstn = 1'b1;
    ignore(5);
    do_start(MW, 3);
    run_frame(MW, 3, 3 * MW, 2, 0);
    chk("wide_last_bottom_right", win[DW-1:0], DW'(3 * MW - 1));
    after_frame;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/gray_window_3x3.md
GRAY_WINDOW_3X3 -- requirements
Module: gray_window_3x3

Interface
REQ-001 The block SHALL provide parameter MAX_WIDTH, default 640: maximum image width in pixels and depth of each line buffer.
REQ-002 The block SHALL provide parameter DW, default 8: gray pixel width in bits.
REQ-003 The block SHALL have port clk  input  1: single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rstn  input  1: reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port start  input  1: one-cycle frame-start pulse.
REQ-006 The block SHALL have port width  input  16: image width in pixels, sampled on start.
REQ-007 The block SHALL have port height  input  16: image height in pixels, sampled on start.
REQ-008 The block SHALL have port pix_in  input  DW: gray pixel, raster order from rgb2gray.
REQ-009 The block SHALL have port pix_valid  input  1: pix_in is valid this cycle.
REQ-010 The block SHALL have port win  output  9*DW: 3x3 window, row-major; win[9*DW-1 -: DW] = top-left, win[DW-1:0] = bottom-right.
REQ-011 The block SHALL have port win_valid  output  1: win is valid this cycle.
REQ-012 The block SHALL have port busy  output  1: high in state RUN.
REQ-013 The block SHALL have port frame_done  output  1: one-cycle pulse after the last pixel of a frame.
REQ-014 The block SHALL have port cfg_err  output  1: the last start carried an illegal size.

Function
REQ-015 The block SHALL implement states IDLE, RUN and DONE.
REQ-016 On start in any state, the block SHALL latch width and height, clear the column and row counters and the 3-column shift registers, and enter RUN.
- Exception: if width<3, height<3 or width>MAX_WIDTH, it SHALL instead set cfg_err=1 and enter IDLE.
REQ-017 A legal start SHALL clear cfg_err.
REQ-018 In IDLE and DONE, the block SHALL ignore pix_valid.
REQ-019 In the cycle start is high, the block SHALL ignore pix_valid.
REQ-020 In RUN, each cycle with pix_valid=1 SHALL accept one pixel at (row r, col c):
- write pix_in to line buffer 0 at address c;
- move the old line buffer 0 entry at c to line buffer 1 at c;
- shift the column {lb1[c], lb0[c], pix_in} into the 3-column window registers.
REQ-021 Columns SHALL count 0..width-1; on reaching width-1, col SHALL wrap to 0 and row SHALL increment.
REQ-022 A window SHALL be emitted only for accepted pixels with r>=2 and c>=2.
- win_valid SHALL be high for exactly one cycle, registered, one clock after the accepting edge.
- win SHALL hold pixels (r-2..r, c-2..c).
- Output window count per frame = (width-2)*(height-2); no border padding.
REQ-023 Windows SHALL never mix pixels from different rows: col 0 and col 1 of each row SHALL produce no window.
REQ-024 win SHALL hold its value when win_valid=0.
REQ-025 Pixel gaps (pix_valid=0) SHALL NOT change any state or the window contents.
REQ-026 Acceptance of pixel (height-1, width-1) SHALL move the FSM to DONE.
- frame_done SHALL pulse one cycle later, in the same cycle as the final win_valid.
- The FSM SHALL then return to IDLE.
REQ-027 Line-buffer contents SHALL NOT require reset; output correctness SHALL rely only on the r/c gating.
REQ-028 A start mid-frame SHALL abort the frame without emitting frame_done for it.
- Any win_valid already registered SHALL still complete its one cycle.

Reset
REQ-029 While rstn=0, the block SHALL force state IDLE, counters 0, win=0, win_valid=0, busy=0, frame_done=0 and cfg_err=0, independent of clk.
REQ-030 After rstn deasserts, the block SHALL accept nothing until a start is received.

Verification
REQ-031 Verification SHALL cover: start with width=5, height=4, then 20 pixels of value 10*r+c, continuous -> exactly 6 win_valid pulses; first win = {0,1,2,10,11,12,20,21,22}; frame_done coincides with the 6th pulse.
REQ-032 Verification SHALL cover: same frame with pix_valid toggling 1/0 at random -> identical 6 windows in identical order; no win_valid during gaps beyond the registered pulse.
REQ-033 Verification SHALL cover: start with width=2 or width=MAX_WIDTH+1 -> cfg_err=1, busy=0; subsequent pixels produce no win_valid.
REQ-034 Verification SHALL cover: start, 12 pixels of a 5x4 frame, then start again with width=4, height=3 and 12 new pixels -> no frame_done for the first frame; 2 windows, both containing only new-frame pixels.
REQ-035 Verification SHALL cover: rstn low for 1 cycle mid-frame (async, between clock edges) -> outputs zero immediately; pixels after release ignored until start.
REQ-036 Verification SHALL cover: width=MAX_WIDTH, height=3 with ramp data -> MAX_WIDTH-2 windows; last win bottom-right equals the last pixel.
